// File: rtl/iter_divider_pkg.sv
// rtl/iter_divider_pkg.sv - shared types and sizing for the iterative divider
package iter_divider_pkg;

  localparam int WORD = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  // Counter must be able to hold the full iteration count (0..word).
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/iter_divider_div_step.sv
// rtl/iter_divider_div_step.sv - one restoring-division step (compare and conditional subtract)
module div_step
  import iter_divider_pkg::*;
#(
  parameter int word = WORD
) (
  input  logic [word:0]   rem_shifted,
  input  logic [word-1:0] dvs,
  output logic [word-1:0] next_rem,
  output logic            q_bit
);

  // The compare needs the carried-out bit; the difference always fits in word bits.
  assign q_bit    = (rem_shifted >= {1'b0, dvs});
  assign next_rem = q_bit ? (rem_shifted[word-1:0] - dvs) : rem_shifted[word-1:0];

endmodule

// File: rtl/iter_divider.sv
// rtl/iter_divider.sv - multi-cycle restoring divider for DIV/DIVU feeding HI/LO
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int word = WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            is_signed,
  input  logic [word-1:0] dividend,
  input  logic [word-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [word-1:0] quotient,
  output logic [word-1:0] remainder,
  output logic            div_by_zero
);

  localparam int CW = cnt_width(word);
  localparam logic [CW-1:0] LAST = CW'(word - 1);

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic            sgn, dvd_neg, dvs_neg, zdiv;
  logic [word-1:0] dvs, rem, quo;
  logic [word:0]   rem_sh;
  logic [word-1:0] next_rem;
  logic            q_bit;

  assign rem_sh = {rem, quo[word-1]};

  div_step #(.word(word)) u_step (
    .rem_shifted (rem_sh),
    .dvs         (dvs),
    .next_rem    (next_rem),
    .q_bit       (q_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (divisor == '0) ? SIGN : CALC;
      CALC:    if (cnt == LAST) state_nx = SIGN;
      SIGN:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      sgn         <= 1'b0;
      dvd_neg     <= 1'b0;
      dvs_neg     <= 1'b0;
      zdiv        <= 1'b0;
      dvs         <= '0;
      rem         <= '0;
      quo         <= '0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sgn         <= is_signed;
          dvd_neg     <= is_signed & dividend[word-1];
          dvs_neg     <= is_signed & divisor[word-1];
          dvs         <= (is_signed & divisor[word-1]) ? -divisor : divisor;
          // A zero divisor skips iteration, so keep the raw dividend for the remainder.
          quo         <= (divisor == '0) ? dividend :
                         ((is_signed & dividend[word-1]) ? -dividend : dividend);
          zdiv        <= (divisor == '0);
          rem         <= '0;
          cnt         <= '0;
          div_by_zero <= 1'b0;
        end
        CALC: begin
          rem <= next_rem;
          quo <= {quo[word-2:0], q_bit};
          cnt <= cnt + CW'(1);
        end
        SIGN: begin
          done <= 1'b1;
          if (zdiv) begin
            quotient    <= '1;
            remainder   <= quo;
            div_by_zero <= 1'b1;
          end else begin
            quotient  <= (sgn && (dvd_neg ^ dvs_neg)) ? -quo : quo;
            remainder <= (sgn && dvd_neg) ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// tb/tb_iter_divider.sv - self-checking bench for iter_divider against a transaction-level model
module tb_iter_divider;

  logic        clk, rst_n, start, is_signed;
  logic [31:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [31:0] quotient, remainder;

  int n_pass = 0;
  int n_total = 0;

  iter_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Returns {div_by_zero, quotient, remainder} from plain integer arithmetic.
  function automatic logic [64:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return {1'b1, 32'hFFFFFFFF, a};
    if (s) begin
      sa = $signed(a);
      sb = $signed(b);
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {1'b0, q[31:0], r[31:0]};
  endfunction

  longint      ecount = 0;
  longint      m_due = 0;
  logic        m_busy, m_done, m_z, p_z;
  logic [31:0] m_q, m_r, p_q, p_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_q    <= '0;
      m_r    <= '0;
      m_z    <= 1'b0;
    end else begin
      ecount <= ecount + 1;
      m_done <= 1'b0;
      if (m_busy) begin
        if (ecount == m_due) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_q    <= p_q;
          m_r    <= p_r;
          m_z    <= p_z;
        end
      end else if (start) begin
        m_busy <= 1'b1;
        m_z    <= 1'b0;
        m_due  <= ecount + ((divisor == 32'd0) ? 1 : 33);
        {p_z, p_q, p_r} <= ref_div(is_signed, dividend, divisor);
      end
    end
  end

  always @(negedge clk) begin
    check("busy", {31'd0, busy}, {31'd0, m_busy});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("quotient", quotient, m_q);
    check("remainder", remainder, m_r);
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_z});
  end

  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 100);
    if (!done) check("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic op(input string nm, input bit s, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] eq, input logic [31:0] er, input bit ez, input int lat);
    int n;
    @(posedge clk); #1;
    start = 1'b1; is_signed = s; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = $urandom;
    check({nm, "_busy_e0"}, {31'd0, busy}, 32'd1);
    check({nm, "_dbz_clr"}, {31'd0, div_by_zero}, 32'd0);
    wait_done(n);
    check({nm, "_latency"}, n, lat);
    check({nm, "_q"}, quotient, eq);
    check({nm, "_r"}, remainder, er);
    check({nm, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    check({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
    check({nm, "_model_q"}, m_q, eq);
    check({nm, "_model_r"}, m_r, er);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_q", quotient, 32'd0);
    rst_n = 1'b1;

    op("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
    op("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 33);
    op("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 33);
    op("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 33);
    op("divu_5_0", 1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 1);
    op("divu_9_3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 33);

    // Ignored start mid-operation, then back-to-back start in the done cycle.
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    repeat (9) begin @(posedge clk); #1; n++; end
    start = 1'b1; dividend = 32'd50; divisor = 32'd3;
    @(posedge clk); #1;
    n++;
    start = 1'b0;
    while (!done && n < 100) begin @(posedge clk); #1; n++; end
    check("ignore_latency", n, 33);
    check("ignore_q", quotient, 32'd14);
    check("ignore_r", remainder, 32'd2);
    start = 1'b1; dividend = 32'd1000; divisor = 32'd10;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_done_drop", {31'd0, done}, 32'd0);
    check("b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(n);
    check("b2b_latency", n, 33);
    check("b2b_q", quotient, 32'd100);
    check("b2b_r", remainder, 32'd0);

    // Reset in the middle of an operation.
    @(posedge clk); #1;
    start = 1'b1; is_signed = 1'b0; dividend = 32'd123456; divisor = 32'd789;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_q", quotient, 32'd0);
    check("rst_r", remainder, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    op("post_rst", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 33);

    // Random traffic, including starts while busy and in done cycles.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      is_signed = $urandom_range(0, 1);
      dividend = ($urandom_range(0, 15) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 7))
        0:       divisor = 32'd0;
        1:       divisor = 32'hFFFFFFFF;
        2, 3:    divisor = $urandom_range(1, 20);
        default: divisor = $urandom;
      endcase
    end
    start = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
